// File: rtl/normalizer_32bit_pkg.sv
// Shared datapath constants and FSM state type for the iterative normalizer.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package normalizer_32bit_pkg;

    localparam int DATA_W = 32;
    localparam int CNT_W  = 6;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/normalizer_32bit_if.sv
// Operand/result handshake bundle between a producer/consumer and the normalizer.
// Latency: n/a (wires only).
// Backpressure: valid/ready in both directions.
interface normalizer_32bit_if;
    import normalizer_32bit_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] data_in;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] data_out;
    logic [CNT_W-1:0]  lz_count;
    logic              zero;

    modport master (
        output in_valid, data_in, out_ready,
        input  in_ready, out_valid, data_out, lz_count, zero
    );

    modport slave (
        input  in_valid, data_in, out_ready,
        output in_ready, out_valid, data_out, lz_count, zero
    );

endinterface

// File: rtl/normalizer_32bit.sv
// Iterative left-normalizer: shifts one bit per cycle until bit 31 is set, reports leading zeros.
// Latency: 1 cycle for zero or msb-set operands, otherwise 1 + lz cycles (max 32).
// Backpressure: one operand in flight; result held in DONE until out_ready, in_ready only in IDLE.
module normalizer_32bit
    import normalizer_32bit_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_rst_n,
    normalizer_32bit_if.slave bus
);

    state_t            state, state_nxt;
    logic [DATA_W-1:0] shreg, shreg_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic              zero_q, zero_nxt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state  <= IDLE;
            shreg  <= '0;
            cnt    <= '0;
            zero_q <= 1'b0;
        end else begin
            state  <= state_nxt;
            shreg  <= shreg_nxt;
            cnt    <= cnt_nxt;
            zero_q <= zero_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        shreg_nxt = shreg;
        cnt_nxt   = cnt;
        zero_nxt  = zero_q;
        case (state)
            IDLE: begin
                if (bus.in_valid) begin
                    shreg_nxt = bus.data_in;
                    cnt_nxt   = '0;
                    zero_nxt  = 1'b0;
                    if (bus.data_in == '0) begin
                        // Nothing to shift: report the full width as the leading-zero count.
                        state_nxt = DONE;
                        cnt_nxt   = CNT_W'(DATA_W);
                        zero_nxt  = 1'b1;
                    end else if (bus.data_in[DATA_W-1]) begin
                        state_nxt = DONE;
                    end else begin
                        state_nxt = SHIFT;
                    end
                end
            end
            SHIFT: begin
                shreg_nxt = {shreg[DATA_W-2:0], 1'b0};
                cnt_nxt   = cnt + 1'b1;
                // Operand is nonzero, so this terminates after at most 31 shifts.
                if (shreg[DATA_W-2]) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == DONE);
    assign bus.data_out  = shreg;
    assign bus.lz_count  = cnt;
    assign bus.zero      = zero_q;

endmodule

// File: tb/tb_normalizer_32bit.sv
// Bench for normalizer_32bit: directed corner operands plus randomized traffic against a reference model.
module tb_normalizer_32bit;
    import normalizer_32bit_pkg::*;

    logic i_clk = 1'b0;
    logic i_rst_n;

    normalizer_32bit_if bus();

    normalizer_32bit dut (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .bus     (bus)
    );

    always #5 i_clk = ~i_clk;

    int checks = 0;
    int errors = 0;

    // Reference model state: one operand in flight, with the cycle its result becomes visible.
    bit          busy = 1'b0;
    int unsigned cyc = 0;
    int unsigned done_at = 0;
    logic [31:0] exp_data = '0;
    logic [31:0] exp_lz = '0;
    logic [31:0] exp_zero = '0;

    function automatic int ref_lz(input logic [31:0] d);
        for (int i = 31; i >= 0; i--) begin
            if (d[i]) return 31 - i;
        end
        return 32;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s: timed out at %0t", name, $time);
    endtask

    always @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            busy = 1'b0;
        end else begin
            int unsigned prev;
            int          lz;
            prev = cyc;
            cyc  = cyc + 1;
            if (busy) begin
                if (prev >= done_at && bus.out_ready) busy = 1'b0;
            end else if (bus.in_valid) begin
                lz       = ref_lz(bus.data_in);
                exp_lz   = 32'(lz);
                exp_data = bus.data_in << lz;
                exp_zero = {31'd0, bus.data_in == 32'd0};
                done_at  = cyc + ((lz == 32) ? 0 : lz);
                busy     = 1'b1;
            end
        end
    end

    always @(negedge i_clk) begin
        if (!i_rst_n) begin
            check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
            check("rst_data_out", bus.data_out, 32'd0);
            check("rst_lz_count", {26'd0, bus.lz_count}, 32'd0);
            check("rst_zero", {31'd0, bus.zero}, 32'd0);
        end else begin
            bit ev;
            ev = busy && (cyc >= done_at);
            check("in_ready", {31'd0, bus.in_ready}, {31'd0, !busy});
            check("out_valid", {31'd0, bus.out_valid}, {31'd0, ev});
            if (ev) begin
                check("data_out", bus.data_out, exp_data);
                check("lz_count", {26'd0, bus.lz_count}, exp_lz);
                check("zero", {31'd0, bus.zero}, exp_zero);
            end
        end
    end

    task automatic wait_idle();
        int n = 0;
        while (!bus.in_ready && n < 100) begin
            @(negedge i_clk);
            n++;
        end
        if (!bus.in_ready) timeout("wait_idle");
    endtask

    task automatic wait_valid(output int lat);
        lat = 1;
        while (!bus.out_valid && lat < 40) begin
            @(negedge i_clk);
            lat++;
        end
        if (!bus.out_valid) timeout("wait_valid");
    endtask

    task automatic run_op(input logic [31:0] d, input int hold, input logic [31:0] xd,
                          input int xlz, input bit xz, input int xlat);
        int lat;
        @(negedge i_clk);
        wait_idle();
        bus.in_valid  = 1'b1;
        bus.data_in   = d;
        bus.out_ready = 1'b0;
        @(negedge i_clk);
        bus.in_valid = 1'b0;
        bus.data_in  = $urandom;
        wait_valid(lat);
        check("op_latency", 32'(lat), 32'(xlat));
        check("op_data", bus.data_out, xd);
        check("op_lz", {26'd0, bus.lz_count}, 32'(xlz));
        check("op_zero", {31'd0, bus.zero}, {31'd0, xz});
        repeat (hold) begin
            bus.in_valid = 1'($urandom_range(0, 1));
            bus.data_in  = $urandom;
            @(negedge i_clk);
            check("hold_in_ready", {31'd0, bus.in_ready}, 32'd0);
        end
        check("hold_data", bus.data_out, xd);
        check("hold_lz", {26'd0, bus.lz_count}, 32'(xlz));
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge i_clk);
        bus.out_ready = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.data_in   = '0;
        i_rst_n       = 1'b1;
        #1 i_rst_n = 1'b0;
        #1;
        check("reset_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("reset_lz", {26'd0, bus.lz_count}, 32'd0);
        repeat (2) @(negedge i_clk);
        #2 i_rst_n = 1'b1;
        @(negedge i_clk);
        check("reset_in_ready", {31'd0, bus.in_ready}, 32'd1);

        run_op(32'h8000_0000, 0, 32'h8000_0000, 0, 1'b0, 1);
        run_op(32'h0000_0001, 0, 32'h8000_0000, 31, 1'b0, 32);
        run_op(32'h0000_0000, 0, 32'h0000_0000, 32, 1'b1, 1);
        run_op(32'h00F0_1234, 5, 32'hF012_3400, 8, 1'b0, 9);

        // Back-to-back with the consumer always ready.
        @(negedge i_clk);
        wait_idle();
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.data_in   = 32'h4000_0000;
        @(negedge i_clk);
        bus.data_in = 32'h0000_8000;
        wait_valid(lat);
        check("b2b_first_lz", {26'd0, bus.lz_count}, 32'd1);
        @(negedge i_clk);
        check("b2b_ready_after_first", {31'd0, bus.in_ready}, 32'd1);
        @(negedge i_clk);
        bus.in_valid = 1'b0;
        wait_valid(lat);
        check("b2b_second_lz", {26'd0, bus.lz_count}, 32'd16);
        check("b2b_second_latency", 32'(lat), 32'd17);
        @(negedge i_clk);
        check("b2b_ready_after_second", {31'd0, bus.in_ready}, 32'd1);
        bus.out_ready = 1'b0;

        // Reset in the middle of a long shift must discard the operand.
        @(negedge i_clk);
        wait_idle();
        bus.in_valid  = 1'b1;
        bus.data_in   = 32'h0000_0001;
        bus.out_ready = 1'b1;
        @(negedge i_clk);
        bus.in_valid = 1'b0;
        repeat (9) @(negedge i_clk);
        #2 i_rst_n = 1'b0;
        #1;
        check("abort_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("abort_data", bus.data_out, 32'd0);
        check("abort_lz", {26'd0, bus.lz_count}, 32'd0);
        check("abort_zero", {31'd0, bus.zero}, 32'd0);
        @(negedge i_clk);
        #2 i_rst_n = 1'b1;
        @(negedge i_clk);
        check("abort_in_ready", {31'd0, bus.in_ready}, 32'd1);
        repeat (40) @(negedge i_clk);
        bus.out_ready = 1'b0;

        // Randomized traffic; the compare process checks every cycle against the model.
        repeat (6000) begin
            @(negedge i_clk);
            bus.in_valid  = ($urandom_range(0, 3) != 0);
            bus.data_in   = $urandom >> $urandom_range(0, 32);
            bus.out_ready = ($urandom_range(0, 2) != 0);
        end
        @(negedge i_clk);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        @(negedge i_clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/normalizer_32bit.md
NORMALIZER_32BIT -- requirements
Module: normalizer_32bit

Interface
REQ-001 Block SHALL have no parameters; widths SHALL come from shared package constants (DATA_W=32, CNT_W=6).
REQ-002 i_clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 i_rst_n  input  1  asynchronous, active-low reset.
REQ-004 in_valid  input  1  operand present on data_in.
REQ-005 in_ready  output  1  block can accept an operand.
REQ-006 data_in  input  32  operand to normalize.
REQ-007 out_valid  output  1  result present on data_out/lz_count/zero.
REQ-008 out_ready  input  1  consumer accepts the result.
REQ-009 data_out  output  32  operand shifted left until bit 31 = 1 (0 if operand is 0).
REQ-010 lz_count  output  6  leading-zero count / applied left-shift amount, range 0..32.
REQ-011 zero  output  1  operand was 0.

Function
REQ-012 FSM SHALL have three states: IDLE, SHIFT, DONE; in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE.
REQ-013 Accept SHALL occur on an edge with IDLE & in_valid; the operand is loaded into an internal 32-bit register and the count is cleared to 0.
REQ-014 On accept with data_in == 0: next state DONE, data_out = 0, lz_count = 32, zero = 1.
REQ-015 On accept with data_in[31] == 1: next state DONE, data_out = data_in, lz_count = 0, zero = 0.
REQ-016 Otherwise: next state SHIFT, zero = 0.
REQ-017 In SHIFT, each edge SHALL shift the register left by 1 (zero fill) and increment the count by 1; transition to DONE on the edge where the pre-shift register bit 30 is 1.
REQ-018 Latency from accept edge to out_valid SHALL be 1 cycle for zero operands, otherwise 1 + lz cycles (maximum 32 cycles, for lz = 31).
REQ-019 In DONE, data_out, lz_count and zero SHALL hold stable while out_ready = 0.
REQ-020 A DONE & out_ready edge SHALL return to IDLE; in_ready rises the following cycle (no same-cycle accept/complete overlap).
REQ-021 in_valid SHALL be ignored outside IDLE; out_ready SHALL be ignored outside DONE.
REQ-022 Count arithmetic SHALL be 6-bit unsigned and SHALL never exceed 32 (no wrap).
REQ-023 data_out/lz_count/zero SHALL be driven directly from registers (no combinational path from any input).

Reset
REQ-024 Assertion of i_rst_n = 0 SHALL immediately force state IDLE, with internal register, count, lz_count, zero, and out_valid all 0, and in_ready = 1 after reset release.
REQ-025 Reset during SHIFT or DONE SHALL abort the operation silently; no result SHALL be produced for the aborted operand.

Structure
REQ-026 The state enum (IDLE/SHIFT/DONE) and the DATA_W/CNT_W constants SHALL live in the shared datapath package.
REQ-027 The block SHALL be a single module with no sub-module; the iterative shifter is inline, and the combinational barrel shifter SHALL NOT be instantiated.

Verification
REQ-028 data_in = 0x8000_0000 -> out_valid 1 cycle after accept, data_out = 0x8000_0000, lz_count = 0, zero = 0.
REQ-029 data_in = 0x0000_0001 -> out_valid 32 cycles after accept, data_out = 0x8000_0000, lz_count = 31.
REQ-030 data_in = 0x0000_0000 -> out_valid 1 cycle after accept, data_out = 0, lz_count = 32, zero = 1.
REQ-031 data_in = 0x00F0_1234, out_ready held 0 for 5 cycles in DONE -> data_out = 0xF012_3400 and lz_count = 8, stable all 5 cycles; in_ready = 0 throughout; in_valid pulses are ignored.
REQ-032 Back-to-back: 0x4000_0000 then 0x0000_8000 with out_ready = 1 -> results lz = 1, then lz = 16; in_ready = 1 exactly one cycle after each completion.
REQ-033 i_rst_n pulsed low mid-SHIFT (operand 0x0000_0001, cycle 10) -> outputs 0 and out_valid = 0 asynchronously; in_ready = 1 after release; no stale result appears.
